// File: rtl/setpoint_editor_pkg.sv
// ----------------------------------------------------------------------------
// setpoint_editor_pkg
// Shared types and helpers for the setpoint editor.
//   state_t      : editor mode (VIEW = browsing committed values, EDIT = shadow edit)
//   event_t      : one decoded button event per cycle, after priority resolution
//   ns_to_cycles : converts a duration in ns into whole clock cycles
// ----------------------------------------------------------------------------
package setpoint_editor_pkg;

    typedef enum logic {
        VIEW,
        EDIT
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        COMMIT,
        MODE,
        INC,
        DEC,
        NULL_EVT
    } event_t;

    function automatic longint ns_to_cycles(input longint ns, input longint period_ns);
        return ns / period_ns;
    endfunction

endpackage

// File: rtl/setpoint_editor_idle_timer.sv
// ----------------------------------------------------------------------------
// setpoint_editor_idle_timer
// Saturating count of cycles since the last button pulse while editing.
// Optional feature macro: SETPOINT_EDITOR_ACCEL_EN (builds the repeat-gap
// comparison and its gap_elapsed output).
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   clear       : any button pulse this cycle; restarts the count
//   run         : count only while editing; held at zero otherwise
//   gap_elapsed : (accel build) count has reached the repeat-gap length
//   timeout_hit : count has reached the last cycle before an edit is abandoned
// ----------------------------------------------------------------------------
module setpoint_editor_idle_timer #(
`ifdef SETPOINT_EDITOR_ACCEL_EN
    parameter longint GAP_CYCLES     = 10,
`endif
    parameter longint TIMEOUT_CYCLES = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
`ifdef SETPOINT_EDITOR_ACCEL_EN
    output logic gap_elapsed,
`endif
    output logic timeout_hit
);

    // Count must be able to represent both thresholds before saturating.
`ifdef SETPOINT_EDITOR_ACCEL_EN
    localparam longint CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
`else
    localparam longint CNT_MAX = TIMEOUT_CYCLES;
`endif
    localparam int               CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear || !run) begin
            count_reg <= '0;
        end else if (count_reg != CNT_TOP) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign timeout_hit = (count_reg >= TIMEOUT_AT);

`ifdef SETPOINT_EDITOR_ACCEL_EN
    assign gap_elapsed = (count_reg >= CNT_W'(GAP_CYCLES));
`endif

endmodule

// File: rtl/setpoint_editor.sv
// ----------------------------------------------------------------------------
// setpoint_editor
// Turns debounced single-cycle button pulses into a bank of committed
// setpoints. mode selects a parameter (VIEW) or abandons an edit (EDIT);
// plus/minus edit a shadow copy with saturation and hold-to-accelerate;
// button_4 commits the shadow; inactivity abandons the edit.
// Optional feature macro: SETPOINT_EDITOR_ACCEL_EN (large steps after a run of
// fast same-direction pulses; without it every step is STEP_SMALL).
// Ports:
//   clk_i, nReset_i                 : clock, asynchronous active-low reset
//   mode_i/minus_i/plus_i/button_4_i: single-cycle button pulses
//   sel_o                           : selected parameter index
//   editing_o                       : high while editing
//   display_value_o                 : shadow while editing, else committed value
//   params_o                        : committed setpoints, index i at [i*VW +: VW]
//   commit_o / timeout_o            : one-cycle pulses on commit / idle cancel
// ----------------------------------------------------------------------------
module setpoint_editor
    import setpoint_editor_pkg::*;
#(
    parameter int     CLOCK_PERIOD_NS = 20,
    parameter int     NUMBER_PARAMS   = 4,
    parameter int     VALUE_WIDTH     = 12,
    parameter int     MIN_VALUE       = 0,
    parameter int     MAX_VALUE       = 4095,
    parameter int     DEFAULT_VALUE   = 0,
    parameter int     STEP_SMALL      = 1,
    parameter int     STEP_LARGE      = 10,
    parameter int     ACCEL_AFTER     = 8,
    parameter longint ACCEL_GAP_NS    = 64'd200_000_000,
    parameter longint EDIT_TIMEOUT_NS = 64'd5_000_000_000
) (
    input  logic                                 clk_i,
    input  logic                                 nReset_i,
    input  logic                                 mode_i,
    input  logic                                 minus_i,
    input  logic                                 plus_i,
    input  logic                                 button_4_i,
    output logic [$clog2(NUMBER_PARAMS)-1:0]     sel_o,
    output logic                                 editing_o,
    output logic [VALUE_WIDTH-1:0]               display_value_o,
    output logic [NUMBER_PARAMS*VALUE_WIDTH-1:0] params_o,
    output logic                                 commit_o,
    output logic                                 timeout_o
);

    localparam int               SEL_W     = $clog2(NUMBER_PARAMS);
    localparam int               VW        = VALUE_WIDTH;
    localparam int               EW        = VALUE_WIDTH + 1;
    localparam logic [EW-1:0]    MIN_EXT   = EW'(MIN_VALUE);
    localparam logic [EW-1:0]    MAX_EXT   = EW'(MAX_VALUE);
    localparam logic [EW-1:0]    SMALL_EXT = EW'(STEP_SMALL);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUMBER_PARAMS - 1);
    localparam longint TIMEOUT_CYCLES = ns_to_cycles(EDIT_TIMEOUT_NS, longint'(CLOCK_PERIOD_NS));

    // Reject parameter sets that would make saturation or timing meaningless.
    if (NUMBER_PARAMS < 2 || MIN_VALUE >= MAX_VALUE || MAX_VALUE >= (1 << VW) ||
        DEFAULT_VALUE < MIN_VALUE || DEFAULT_VALUE > MAX_VALUE ||
        STEP_SMALL < 1 || STEP_LARGE < STEP_SMALL || ACCEL_AFTER < 1 ||
        ACCEL_GAP_NS < CLOCK_PERIOD_NS || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("setpoint_editor: inconsistent parameter set");
    end

    state_t              state_reg, state_next;
    event_t              evt;
    logic [SEL_W-1:0]    sel_reg;
    logic [VW-1:0]       shadow_reg, stepped, base, cur_param;
    logic [NUMBER_PARAMS*VW-1:0] params_flat;
    logic                commit_reg, timeout_reg;
    logic                in_edit, any_pulse, is_step, timeout_hit, timeout_evt, commit_en;
    logic [EW-1:0]       step_ext, sum_ext, diff_ext, floor_ext;

    // Priority: button_4 > mode > plus/minus; plus+minus together is a null event.
    always_comb begin
        evt = NONE;
        if (button_4_i)                evt = COMMIT;
        else if (mode_i)               evt = MODE;
        else if (plus_i && minus_i)    evt = NULL_EVT;
        else if (plus_i)               evt = INC;
        else if (minus_i)              evt = DEC;
    end

    assign in_edit     = (state_reg == EDIT);
    assign any_pulse   = mode_i | minus_i | plus_i | button_4_i;
    assign is_step     = (evt == INC) || (evt == DEC);
    // A pulse in the expiry cycle keeps the edit alive.
    assign timeout_evt = in_edit && timeout_hit && (evt == NONE);
    assign commit_en   = in_edit && (evt == COMMIT);

`ifdef SETPOINT_EDITOR_ACCEL_EN
    localparam longint        GAP_CYCLES = ns_to_cycles(ACCEL_GAP_NS, longint'(CLOCK_PERIOD_NS));
    localparam logic [EW-1:0] LARGE_EXT  = EW'(STEP_LARGE);
    localparam int            REP_W      = $clog2(ACCEL_AFTER + 2);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(ACCEL_AFTER + 1);
    localparam logic [REP_W-1:0] REP_THR = REP_W'(ACCEL_AFTER);

    logic [REP_W-1:0] rep_reg, rep_next;
    logic             dir_up_reg, gap_elapsed;

    // Entering EDIT always starts a fresh run; a null event breaks the run.
    always_comb begin
        rep_next = rep_reg;
        if (is_step) begin
            if (in_edit && ((evt == INC) == dir_up_reg) && !gap_elapsed)
                rep_next = (rep_reg == REP_MAX) ? rep_reg : rep_reg + 1'b1;
            else
                rep_next = REP_W'(1);
        end else if (evt == NULL_EVT) begin
            rep_next = '0;
        end
    end

    assign step_ext = (rep_next > REP_THR) ? LARGE_EXT : SMALL_EXT;

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            rep_reg    <= '0;
            dir_up_reg <= 1'b0;
        end else begin
            rep_reg <= rep_next;
            if (is_step) dir_up_reg <= (evt == INC);
        end
    end
`else
    assign step_ext = SMALL_EXT;
`endif

    setpoint_editor_idle_timer #(
`ifdef SETPOINT_EDITOR_ACCEL_EN
        .GAP_CYCLES     (GAP_CYCLES),
`endif
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk         (clk_i),
        .rst_n       (nReset_i),
        .clear       (any_pulse),
        .run         (in_edit),
`ifdef SETPOINT_EDITOR_ACCEL_EN
        .gap_elapsed (gap_elapsed),
`endif
        .timeout_hit (timeout_hit)
    );

    // Saturating step, evaluated one bit wider so neither bound can wrap.
    assign cur_param = params_flat[int'(sel_reg) * VW +: VW];
    assign base      = in_edit ? shadow_reg : cur_param;
    assign sum_ext   = {1'b0, base} + step_ext;
    assign diff_ext  = {1'b0, base} - step_ext;
    assign floor_ext = MIN_EXT + step_ext;

    always_comb begin
        stepped = base;
        if (evt == INC)
            stepped = (sum_ext > MAX_EXT) ? MAX_EXT[VW-1:0] : sum_ext[VW-1:0];
        else if (evt == DEC)
            stepped = ({1'b0, base} < floor_ext) ? MIN_EXT[VW-1:0] : diff_ext[VW-1:0];
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) state_reg <= VIEW;
        else           state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            VIEW: if (is_step) state_next = EDIT;
            EDIT: if (evt == COMMIT || evt == MODE || timeout_evt) state_next = VIEW;
            default: state_next = VIEW;
        endcase
    end

    // FSM: outputs
    always_comb begin
        editing_o       = in_edit;
        display_value_o = in_edit ? shadow_reg : cur_param;
    end

    // Selection, shadow and event pulses
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            sel_reg     <= '0;
            shadow_reg  <= VW'(DEFAULT_VALUE);
            commit_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            commit_reg  <= commit_en;
            timeout_reg <= timeout_evt;
            if (!in_edit && evt == MODE)
                sel_reg <= (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;
            if (is_step)
                shadow_reg <= stepped;
        end
    end

    // Committed setpoint bank, one register per parameter
    for (genvar gi = 0; gi < NUMBER_PARAMS; gi++) begin : g_param
        logic [VW-1:0] value_reg;
        always_ff @(posedge clk_i or negedge nReset_i) begin
            if (!nReset_i)
                value_reg <= VW'(DEFAULT_VALUE);
            else if (commit_en && sel_reg == SEL_W'(gi))
                value_reg <= shadow_reg;
        end
        assign params_flat[gi*VW +: VW] = value_reg;
    end

    assign params_o  = params_flat;
    assign sel_o     = sel_reg;
    assign commit_o  = commit_reg;
    assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_setpoint_editor.sv
// ----------------------------------------------------------------------------
// tb_setpoint_editor
// Directed bench for setpoint_editor with a small behavioural model. Expected
// shadow values are queued when a button press is driven and popped when the
// DUT output is sampled on the following falling edge.
// Works with or without SETPOINT_EDITOR_ACCEL_EN.
// ----------------------------------------------------------------------------
module tb_setpoint_editor;

    localparam int NP  = 4;
    localparam int VW  = 8;
    localparam int MINV = 10;
    localparam int MAXV = 200;
    localparam int DEF = 100;
    localparam int ACC_AFTER = 4;
    localparam int GAP_CYC = 20;   // 400 ns / 20 ns
`ifdef SETPOINT_EDITOR_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nReset_i = 1'b0;
    logic          mode_i = 1'b0, minus_i = 1'b0, plus_i = 1'b0, button_4_i = 1'b0;
    logic [1:0]    sel_o;
    logic          editing_o;
    logic [VW-1:0] display_value_o;
    logic [NP*VW-1:0] params_o;
    logic          commit_o, timeout_o;

    int total = 0;
    int bad   = 0;

    // model state
    int exp_param [NP];
    int exp_sel    = 0;
    int exp_shadow = DEF;
    bit exp_edit   = 1'b0;
    int m_rep      = 0;
    bit m_up       = 1'b0;
    logic [31:0] exp_q [$];

    always #10 clk = ~clk;

    setpoint_editor #(
        .CLOCK_PERIOD_NS (20),
        .NUMBER_PARAMS   (NP),
        .VALUE_WIDTH     (VW),
        .MIN_VALUE       (MINV),
        .MAX_VALUE       (MAXV),
        .DEFAULT_VALUE   (DEF),
        .STEP_SMALL      (1),
        .STEP_LARGE      (10),
        .ACCEL_AFTER     (ACC_AFTER),
        .ACCEL_GAP_NS    (400),
        .EDIT_TIMEOUT_NS (2000)
    ) dut (
        .clk_i           (clk),
        .nReset_i        (nReset_i),
        .mode_i          (mode_i),
        .minus_i         (minus_i),
        .plus_i          (plus_i),
        .button_4_i      (button_4_i),
        .sel_o           (sel_o),
        .editing_o       (editing_o),
        .display_value_o (display_value_o),
        .params_o        (params_o),
        .commit_o        (commit_o),
        .timeout_o       (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] packed_params();
        logic [31:0] r;
        int v;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            v = exp_param[i];
            r[i*VW +: VW] = v[VW-1:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) exp_param[i] = DEF;
        exp_sel = 0; exp_shadow = DEF; exp_edit = 1'b0; m_rep = 0; m_up = 1'b0;
    endtask

    // Called on a falling edge: drive for one cycle, return on the next falling edge.
    task automatic pulse(input bit m, input bit mi, input bit pl, input bit b4);
        mode_i = m; minus_i = mi; plus_i = pl; button_4_i = b4;
        @(negedge clk);
        mode_i = 1'b0; minus_i = 1'b0; plus_i = 1'b0; button_4_i = 1'b0;
        $display("txn mode=%0b minus=%0b plus=%0b b4=%0b : sel=%0d editing=%0b display=%0d commit=%0b timeout=%0b",
                 m, mi, pl, b4, sel_o, editing_o, display_value_o, commit_o, timeout_o);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".sel"},     32'(sel_o), 32'(exp_sel));
        chk({tag, ".editing"}, 32'(editing_o), 32'(exp_edit));
        chk({tag, ".display"}, 32'(display_value_o), exp_edit ? 32'(exp_shadow) : 32'(exp_param[exp_sel]));
        chk({tag, ".params"},  params_o, packed_params());
    endtask

    // plus (up=1) or minus after `idle` quiet cycles
    task automatic press(input bit up, input int idle);
        int step, base;
        repeat (idle) @(negedge clk);
        if (!exp_edit) begin
            base  = exp_param[exp_sel];
            m_rep = 1;
        end else begin
            base = exp_shadow;
            if (idle < GAP_CYC && up == m_up)
                m_rep = (m_rep == ACC_AFTER + 1) ? m_rep : m_rep + 1;
            else
                m_rep = 1;
        end
        m_up = up;
        step = (ACCEL && m_rep > ACC_AFTER) ? 10 : 1;
        if (up) exp_shadow = (base + step > MAXV) ? MAXV : base + step;
        else    exp_shadow = (base - step < MINV) ? MINV : base - step;
        exp_edit = 1'b1;
        exp_q.push_back(32'(exp_shadow));
        pulse(1'b0, !up, up, 1'b0);
        chk("press.display", 32'(display_value_o), exp_q.pop_front());
        chk("press.editing", 32'(editing_o), 32'd1);
    endtask

    task automatic do_mode();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        if (exp_edit) exp_edit = 1'b0;
        else          exp_sel = (exp_sel + 1) % NP;
        check_state("mode");
        chk("mode.commit", 32'(commit_o), 32'd0);
    endtask

    task automatic do_commit(input bit with_plus);
        bit fired;
        fired = exp_edit;
        if (exp_edit) begin
            exp_param[exp_sel] = exp_shadow;
            exp_edit = 1'b0;
        end
        pulse(1'b0, 1'b0, with_plus, 1'b1);
        chk("commit.pulse", 32'(commit_o), 32'(fired));
        check_state("commit");
        @(negedge clk);
        chk("commit.pulse_end", 32'(commit_o), 32'd0);
    endtask

    task automatic do_null();
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        if (exp_edit) m_rep = 0;
        check_state("null");
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset.commit", 32'(commit_o), 32'd0);
        chk("reset.timeout", 32'(timeout_o), 32'd0);
        nReset_i = 1'b1;
        @(negedge clk);

        // selection walk and wrap
        repeat (5) do_mode();

        // basic edit and commit on sel 1
        press(1'b1, 0);
        press(1'b1, 0);
        do_commit(1'b0);

        // fast run on sel 2, then drive into the upper limit, then abandon
        do_mode();
        repeat (7) press(1'b1, 9);
        repeat (100) press(1'b1, 0);
        chk("upper_limit", 32'(display_value_o), 32'(MAXV));
        do_mode();

        // slow run never accelerates, then commit
        repeat (7) press(1'b1, 29);
        do_commit(1'b0);

        // drive into the lower limit, then abandon
        repeat (120) press(1'b0, 0);
        chk("lower_limit", 32'(display_value_o), 32'(MINV));
        do_mode();

        // button_4 with plus commits the pre-step shadow; button_4 in VIEW does nothing
        press(1'b1, 0);
        do_commit(1'b1);
        do_commit(1'b0);

        // plus+minus is a null event in EDIT and in VIEW
        press(1'b1, 0);
        do_null();
        do_mode();
        do_null();

        // idle timeout
        press(1'b1, 0);
        repeat (99) @(negedge clk);
        chk("timeout.early", 32'(timeout_o), 32'd0);
        chk("timeout.still_editing", 32'(editing_o), 32'd1);
        @(negedge clk);
        chk("timeout.pulse", 32'(timeout_o), 32'd1);
        exp_edit = 1'b0;
        check_state("timeout");
        @(negedge clk);
        chk("timeout.pulse_end", 32'(timeout_o), 32'd0);

        // asynchronous reset in the middle of an edit
        do_mode();
        press(1'b0, 0);
        #3 nReset_i = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        chk("async_reset.commit", 32'(commit_o), 32'd0);
        chk("async_reset.timeout", 32'(timeout_o), 32'd0);
        @(negedge clk);
        nReset_i = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/setpoint_editor.md
# setpoint_editor

Consumes the debounced, auto-repeating single-cycle button pulses produced by the button filter stage (mode / minus / plus / button_4) and turns them into a bank of actuator setpoints. Mode selects the parameter, plus/minus edit a shadow copy with saturation and hold-to-accelerate, button_4 commits, and inactivity cancels. Sits between the button front end and the actuator control core and display.

## Interface
- CLOCK_PERIOD_NS, 20, clk_i period
- NUMBER_PARAMS, 4, number of editable setpoints (≥2)
- VALUE_WIDTH, 12, setpoint width (unsigned)
- MIN_VALUE, 0, lower saturation limit
- MAX_VALUE, 4095, upper saturation limit (MIN_VALUE < MAX_VALUE < 2^VALUE_WIDTH)
- DEFAULT_VALUE, 0, reset value of every setpoint (MIN_VALUE ≤ DEFAULT_VALUE ≤ MAX_VALUE)
- STEP_SMALL, 1, normal step
- STEP_LARGE, 10, accelerated step
- ACCEL_AFTER, 8, consecutive same-direction pulses before the large step applies
- ACCEL_GAP_NS, 200_000_000, pulse gap that breaks a repeat run
- EDIT_TIMEOUT_NS, 5_000_000_000, inactivity that cancels an edit
- clk_i, in, 1, system clock
- nReset_i, in, 1, asynchronous active-low reset
- mode_i / minus_i / plus_i / button_4_i, in, 1 each, single-cycle pulses synchronous to clk_i
- sel_o, out, $clog2(NUMBER_PARAMS), selected parameter index
- editing_o, out, 1, high in EDIT
- display_value_o, out, VALUE_WIDTH, shadow in EDIT, committed value of sel_o in VIEW
- params_o, out, NUMBER_PARAMS*VALUE_WIDTH, committed setpoints; index i at bits [i*VALUE_WIDTH +: VALUE_WIDTH]
- commit_o, out, 1, one-cycle pulse when a setpoint is written
- timeout_o, out, 1, one-cycle pulse when an edit is cancelled by inactivity

## Operation
- Reset: state VIEW, sel_o=0, every setpoint=DEFAULT_VALUE, shadow=DEFAULT_VALUE, commit_o=timeout_o=0, idle counter=0, repeat count=0.
- Pulse priority within one cycle: button_4 > mode > plus/minus. plus and minus together is a null event. It changes no value, but it clears the idle counter and the repeat run.
- VIEW:
  - mode: sel_o := (sel_o+1) mod NUMBER_PARAMS.
  - plus or minus: shadow := setpoint[sel_o] stepped once with STEP_SMALL; enter EDIT; repeat count := 1.
  - button_4: ignored.
- EDIT:
  - plus or minus: step the shadow.
  - button_4: setpoint[sel_o] := shadow; commit_o pulse; return to VIEW.
  - mode: discard the shadow; return to VIEW; sel_o unchanged.
  - Idle timeout: discard the shadow; timeout_o pulse; return to VIEW.
- Step: the run increments on a same-direction pulse whose gap is below ACCEL_GAP_NS. Otherwise the run resets to 1. Step = STEP_LARGE when the repeat count (after update) exceeds ACCEL_AFTER, else STEP_SMALL. The repeat count saturates at ACCEL_AFTER+1.
- Saturation, computed at VALUE_WIDTH+1 bits:
  - plus: shadow := (shadow > MAX_VALUE−step) ? MAX_VALUE : shadow+step.
  - minus: shadow := (shadow < MIN_VALUE+step) ? MIN_VALUE : shadow−step.
  - Never wraps.

## Timing
- All state is registered. A pulse at edge N takes effect in sel_o, editing_o, display_value_o and params_o after edge N+1 (one-cycle latency).
- commit_o and timeout_o are high for exactly the cycle following the triggering edge.
- The idle counter runs in EDIT, clears on any pulse, and saturates.
  - Gap test: count ≥ ACCEL_GAP_NS/CLOCK_PERIOD_NS at pulse arrival.
  - Timeout fires when count reaches EDIT_TIMEOUT_NS/CLOCK_PERIOD_NS − 1 with no pulse that cycle. A pulse in that same cycle wins.
- Back-to-back pulses on consecutive cycles are each processed; there is no input buffering.
- Reset assertion at any point (including mid-EDIT) returns immediately to the reset state. Uncommitted shadows are lost.

## Configuration
- SETPOINT_EDITOR_ACCEL_EN:
  - Defined: acceleration as described.
  - Undefined: the repeat counter and gap comparison are not built; every step is STEP_SMALL. Timeout behaviour is unchanged.

## Structure
- Package setpoint_editor_pkg:
  - state typedef (VIEW, EDIT).
  - Decoded event typedef (NONE, COMMIT, MODE, INC, DEC, NULL_EVT).
  - Helper function deriving cycle counts from ns parameters.
- Sub-module setpoint_editor_idle_timer:
  - Saturating idle counter.
  - Outputs gap_elapsed and timeout_hit.
  - Inputs clear and run.

## Test plan
Bench parameters: CLOCK_PERIOD_NS=20, VALUE_WIDTH=8, MIN=10, MAX=200, DEFAULT=100, STEP_SMALL=1, STEP_LARGE=10, ACCEL_AFTER=4, ACCEL_GAP_NS=400, EDIT_TIMEOUT_NS=2000.
- Reset, 3× mode, then 2× mode → sel_o goes 0,1,2,3, then wraps to 0 and 1; params_o all 100; editing_o=0.
- plus, plus, then button_4 → display 101, 102; commit_o one cycle; param[sel]=102; editing_o=0.
- 7 plus pulses 10 cycles apart (accel enabled) → shadow 101,102,103,104,114,124,134. Same pulses 30 cycles apart → 101…107. Macro undefined → 101…107 in both cases.
- From 195: 3× plus with accel active → saturates at 200. From 12: minus run → 11, 10, then stays 10.
- Enter EDIT, then idle 100 cycles → timeout_o pulse at cycle 100; param unchanged. Enter EDIT, then mode → VIEW, sel unchanged, no commit_o.
- Edge cases:
  - button_4+plus same cycle in EDIT → commit of the pre-step shadow.
  - plus+minus same cycle → no change.
  - nReset_i low mid-EDIT → all outputs at reset values immediately.
